lcd_rect_arbiter: RTL and testbench

LCD_RECT_ARBITER -- requirements
Module: lcd_rect_arbiter

---
 rtl/lcd_rect_arbiter_pkg.sv | 24 ++
 rtl/lcd_rect_arbiter_rr_select.sv | 33 +++
 rtl/lcd_rect_arbiter.sv | 168 ++++++++++++++++
 tb/tb_lcd_rect_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_rect_arbiter_pkg.sv
// Shared constants and types for the rectangle-fill arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lcd_rect_arbiter_pkg;

  localparam int DEF_LCD_WIDTH  = 240;
  localparam int DEF_LCD_HEIGHT = 320;
  localparam int COLOUR_W       = 16;   // RGB565
  localparam int X_W            = 8;
  localparam int Y_W            = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DRAW = 2'd2,
    DONE = 2'd3
  } state_e;

  // Index width that stays at least one bit for a single requester.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lcd_rect_arbiter_rr_select.sv
// Round-robin pick: first set req bit searched upward from last_idx+1 (wrapping).
// Latency: purely combinational.
// Backpressure: none; found=0 when no request is pending.
module rr_select #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_idx,
  output logic [NUM_REQ-1:0] winner,
  output logic [IDX_W-1:0]   winner_idx,
  output logic               found
);

  logic [IDX_W-1:0] cand;

  // Walk the ring starting just after the previous owner; first hit wins.
  always_comb begin
    winner     = '0;
    winner_idx = '0;
    found      = 1'b0;
    cand       = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IDX_W'((int'(last_idx) + i) % NUM_REQ);
      if (!found && req[cand]) begin
        found        = 1'b1;
        winner[cand] = 1'b1;
        winner_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/lcd_rect_arbiter.sv
// Arbitrates rectangle-fill requests and streams clipped pixels to the display.
// Latency: first pixelWrite two cycles after req is seen in IDLE; done one cycle after last accept.
// Backpressure: pixelWrite holds address/data until pixelReady; requesters wait on done.
module lcd_rect_arbiter
  import lcd_rect_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int LCD_WIDTH  = DEF_LCD_WIDTH,
  parameter int LCD_HEIGHT = DEF_LCD_HEIGHT
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*X_W-1:0]       reqX0,
  input  logic [NUM_REQ*Y_W-1:0]       reqY0,
  input  logic [NUM_REQ*X_W-1:0]       reqW,
  input  logic [NUM_REQ*Y_W-1:0]       reqH,
  input  logic [NUM_REQ*COLOUR_W-1:0]  reqColour,
  output logic [NUM_REQ-1:0]           done,
  output logic [NUM_REQ-1:0]           grant,
  output logic                         busy,
  output logic [X_W-1:0]               xAddr,
  output logic [Y_W-1:0]               yAddr,
  output logic [COLOUR_W-1:0]          pixelData,
  output logic                         pixelWrite,
  input  logic                         pixelReady
);

  localparam int         IDX_W = idx_width(NUM_REQ);
  localparam logic [9:0] X_LIM = 10'(LCD_WIDTH);
  localparam logic [9:0] Y_LIM = 10'(LCD_HEIGHT);

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]     own_q, own_d;
  logic [IDX_W-1:0]     last_q, last_d;
  logic [X_W-1:0]       x_q, x_d, x0_q, x0_d, x_end_q, x_end_d;
  logic [Y_W-1:0]       y_q, y_d, y_end_q, y_end_d;
  logic [COLOUR_W-1:0]  colour_q, colour_d;

  logic [NUM_REQ-1:0]   rr_winner;
  logic [IDX_W-1:0]     rr_idx;
  logic                 rr_found;

  logic [X_W-1:0]       cmd_x0, cmd_w;
  logic [Y_W-1:0]       cmd_y0, cmd_h;
  logic [COLOUR_W-1:0]  cmd_colour;
  logic [9:0]           x_sum, y_sum, x_lim, y_lim;
  logic                 cmd_empty;

  rr_select #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_select (
    .req        (req),
    .last_idx   (last_q),
    .winner     (rr_winner),
    .winner_idx (rr_idx),
    .found      (rr_found)
  );

  // Owner's command slice; only consumed while in LOAD.
  assign cmd_x0     = reqX0[int'(own_q)*X_W +: X_W];
  assign cmd_y0     = reqY0[int'(own_q)*Y_W +: Y_W];
  assign cmd_w      = reqW[int'(own_q)*X_W +: X_W];
  assign cmd_h      = reqH[int'(own_q)*Y_W +: Y_W];
  assign cmd_colour = reqColour[int'(own_q)*COLOUR_W +: COLOUR_W];

  // Far edge computed wide so X0+W / Y0+H cannot wrap before clipping.
  assign x_sum = {2'b00, cmd_x0} + {2'b00, cmd_w};
  assign y_sum = {1'b0, cmd_y0} + {1'b0, cmd_h};
  assign x_lim = (x_sum < X_LIM) ? x_sum : X_LIM;
  assign y_lim = (y_sum < Y_LIM) ? y_sum : Y_LIM;
  assign cmd_empty = (cmd_w == '0) || (cmd_h == '0) ||
                     ({2'b00, cmd_x0} >= X_LIM) || ({1'b0, cmd_y0} >= Y_LIM);

  // Next-state: grant in IDLE, latch+clip in LOAD, raster scan in DRAW.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    own_d    = own_q;
    last_d   = last_q;
    x_d      = x_q;
    y_d      = y_q;
    x0_d     = x0_q;
    x_end_d  = x_end_q;
    y_end_d  = y_end_q;
    colour_d = colour_q;
    case (state_q)
      IDLE: begin
        if (rr_found) begin
          state_d = LOAD;
          grant_d = rr_winner;
          own_d   = rr_idx;
          last_d  = rr_idx;
        end
      end
      LOAD: begin
        if (cmd_empty) begin
          state_d = DONE;
        end else begin
          state_d  = DRAW;
          x_d      = cmd_x0;
          y_d      = cmd_y0;
          x0_d     = cmd_x0;
          colour_d = cmd_colour;
          x_end_d  = X_W'(x_lim - 10'd1);
          y_end_d  = Y_W'(y_lim - 10'd1);
        end
      end
      DRAW: begin
        if (pixelReady) begin
          if (x_q == x_end_q) begin
            if (y_q == y_end_q) begin
              state_d = DONE;
            end else begin
              x_d = x0_q;
              y_d = y_q + 9'd1;
            end
          end else begin
            x_d = x_q + 8'd1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        grant_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any rectangle in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      own_q    <= '0;
      last_q   <= IDX_W'(NUM_REQ - 1);
      x_q      <= '0;
      y_q      <= '0;
      x0_q     <= '0;
      x_end_q  <= '0;
      y_end_q  <= '0;
      colour_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      own_q    <= own_d;
      last_q   <= last_d;
      x_q      <= x_d;
      y_q      <= y_d;
      x0_q     <= x0_d;
      x_end_q  <= x_end_d;
      y_end_q  <= y_end_d;
      colour_q <= colour_d;
    end
  end

  assign grant      = grant_q;
  assign done       = (state_q == DONE) ? grant_q : '0;
  assign busy       = (state_q != IDLE);
  assign pixelWrite = (state_q == DRAW);
  assign xAddr      = x_q;
  assign yAddr      = y_q;
  assign pixelData  = colour_q;

endmodule

// File: tb/tb_lcd_rect_arbiter.sv
// Directed bench for lcd_rect_arbiter: vector table plus hand-written corner sequences.
// Latency: n/a.
// Backpressure: pixelReady driven constant or toggling per vector.
module tb_lcd_rect_arbiter;

  logic        clock;
  logic        reset_n;
  logic [1:0]  req;
  logic [15:0] reqX0;
  logic [17:0] reqY0;
  logic [15:0] reqW;
  logic [17:0] reqH;
  logic [31:0] reqColour;
  logic [1:0]  done;
  logic [1:0]  grant;
  logic        busy;
  logic [7:0]  xAddr;
  logic [8:0]  yAddr;
  logic [15:0] pixelData;
  logic        pixelWrite;
  logic        pixelReady;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  x;
    logic [8:0]  y;
    logic [15:0] d;
  } px_t;

  typedef struct {
    int          id;
    int          x0;
    int          y0;
    int          w;
    int          h;
    logic [15:0] col;
    bit          tog;
    int          cnt;
    int          ex0;
    int          ex1;
    int          ey0;
    int          ey1;
  } vec_t;

  px_t        px_log[$];
  logic [1:0] done_log[$];
  bit         stall_q;
  logic [32:0] held_q;
  vec_t       vecs[10];

  lcd_rect_arbiter dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req        (req),
    .reqX0      (reqX0),
    .reqY0      (reqY0),
    .reqW       (reqW),
    .reqH       (reqH),
    .reqColour  (reqColour),
    .done       (done),
    .grant      (grant),
    .busy       (busy),
    .xAddr      (xAddr),
    .yAddr      (yAddr),
    .pixelData  (pixelData),
    .pixelWrite (pixelWrite),
    .pixelReady (pixelReady)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_cmd(input int id, input int x0, input int y0, input int w, input int h,
                         input logic [15:0] col);
    reqX0[id*8 +: 8]      = 8'(x0);
    reqY0[id*9 +: 9]      = 9'(y0);
    reqW[id*8 +: 8]       = 8'(w);
    reqH[id*9 +: 9]       = 9'(h);
    reqColour[id*16 +: 16] = col;
  endtask

  task automatic wait_done(input int n, input int budget, input bit tog, output logic ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      tick();
      if (done_log.size() >= n) begin
        ok = 1'b1;
        break;
      end
      pixelReady = tog ? ~pixelReady : 1'b1;
    end
  endtask

  // Compare logged writes against a raster scan of the expected rectangle.
  task automatic check_rect(input string name, input int cnt, input int ex0, input int ex1,
                            input int ey0, input int ey1, input logic [15:0] col);
    int idx;
    chk({name, "_count"}, px_log.size(), cnt);
    if (px_log.size() == cnt && cnt > 0) begin
      idx = 0;
      for (int y = ey0; y <= ey1; y++) begin
        for (int x = ex0; x <= ex1; x++) begin
          chk($sformatf("%s_px%0d", name, idx),
              {px_log[idx].x, px_log[idx].y, px_log[idx].d},
              {8'(x), 9'(y), col});
          idx++;
        end
      end
    end
  endtask

  // Observe the pixel port and done pulses mid-cycle; stalled pixels must hold.
  always @(negedge clock) begin
    if (!reset_n) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        chk("hold_write", pixelWrite, 1'b1);
        chk("hold_addr_data", {xAddr, yAddr, pixelData}, held_q);
      end
      if (pixelWrite && pixelReady) px_log.push_back('{xAddr, yAddr, pixelData});
      if (done != 2'b00) begin
        done_log.push_back(done);
        chk("done_vs_grant", done, grant);
      end
      stall_q = pixelWrite && !pixelReady;
      held_q  = {xAddr, yAddr, pixelData};
    end
  end

  task automatic run_vec(input vec_t v, input int vi);
    logic ok;
    logic [1:0] oh;
    px_log.delete();
    done_log.delete();
    set_cmd(v.id, v.x0, v.y0, v.w, v.h, v.col);
    pixelReady = 1'b1;
    req        = 2'b00;
    req[v.id]  = 1'b1;
    wait_done(1, 2000, v.tog, ok);
    req        = 2'b00;
    pixelReady = 1'b1;
    oh = 2'b00;
    oh[v.id] = 1'b1;
    chk($sformatf("v%0d_done_seen", vi), ok, 1'b1);
    if (ok) chk($sformatf("v%0d_done_owner", vi), done_log[0], oh);
    check_rect($sformatf("v%0d", vi), v.cnt, v.ex0, v.ex1, v.ey0, v.ey1, v.col);
    tick();
  endtask

  initial begin
    logic ok;

    vecs[0] = '{0, 10, 20, 3, 2, 16'hF800, 1'b0, 6, 10, 12, 20, 21};
    vecs[1] = '{0, 10, 20, 3, 2, 16'h07E0, 1'b1, 6, 10, 12, 20, 21};
    vecs[2] = '{1, 238, 318, 5, 5, 16'h001F, 1'b0, 4, 238, 239, 318, 319};
    vecs[3] = '{0, 0, 0, 1, 1, 16'h1234, 1'b0, 1, 0, 0, 0, 0};
    vecs[4] = '{1, 5, 7, 0, 4, 16'hAAAA, 1'b0, 0, 0, 0, 0, 0};
    vecs[5] = '{0, 240, 0, 4, 4, 16'h5555, 1'b0, 0, 0, 0, 0, 0};
    vecs[6] = '{1, 0, 319, 2, 3, 16'hBEEF, 1'b1, 2, 0, 1, 319, 319};
    vecs[7] = '{0, 239, 100, 1, 2, 16'hC0DE, 1'b0, 2, 239, 239, 100, 101};
    vecs[8] = '{1, 0, 5, 240, 1, 16'h0F0F, 1'b0, 240, 0, 239, 5, 5};
    vecs[9] = '{0, 100, 0, 2, 300, 16'h7777, 1'b1, 600, 100, 101, 0, 299};

    reset_n    = 1'b0;
    req        = 2'b00;
    reqX0      = '0;
    reqY0      = '0;
    reqW       = '0;
    reqH       = '0;
    reqColour  = '0;
    pixelReady = 1'b1;
    tick();
    tick();

    // Reset state
    chk("rst_grant", grant, 2'b00);
    chk("rst_done", done, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_write", pixelWrite, 1'b0);
    chk("rst_addr_data", {xAddr, yAddr, pixelData}, 33'd0);
    reset_n = 1'b1;
    tick();

    // First-write latency, then command scramble and req drop mid-draw
    px_log.delete();
    done_log.delete();
    set_cmd(0, 10, 20, 3, 2, 16'hF800);
    req = 2'b01;
    tick();
    chk("lat_load_busy", busy, 1'b1);
    chk("lat_load_grant", grant, 2'b01);
    chk("lat_load_write", pixelWrite, 1'b0);
    tick();
    chk("lat_draw_write", pixelWrite, 1'b1);
    chk("lat_draw_first", {xAddr, yAddr, pixelData}, {8'd10, 9'd20, 16'hF800});
    set_cmd(0, 100, 200, 9, 9, 16'h0000);
    req = 2'b00;
    wait_done(1, 100, 1'b0, ok);
    chk("lat_done_seen", ok, 1'b1);
    if (ok) chk("lat_done_owner", done_log[0], 2'b01);
    chk("lat_idle_grant", grant, 2'b00);
    chk("lat_idle_busy", busy, 1'b0);
    check_rect("lat", 6, 10, 12, 20, 21, 16'hF800);
    tick();

    // Zero-size rectangle: done two cycles after sampling, no writes
    px_log.delete();
    done_log.delete();
    set_cmd(0, 10, 20, 0, 2, 16'h4321);
    req = 2'b01;
    tick();
    chk("zero_load_grant", grant, 2'b01);
    chk("zero_load_done", done, 2'b00);
    tick();
    chk("zero_done_pulse", done, 2'b01);
    chk("zero_done_write", pixelWrite, 1'b0);
    chk("zero_done_busy", busy, 1'b1);
    req = 2'b00;
    tick();
    chk("zero_after_done", done, 2'b00);
    chk("zero_after_grant", grant, 2'b00);
    chk("zero_after_busy", busy, 1'b0);
    chk("zero_px_count", px_log.size(), 0);
    tick();

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // Contention from fresh reset: strict alternation 0,1,0,1
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    px_log.delete();
    done_log.delete();
    set_cmd(0, 0, 0, 1, 1, 16'h000A);
    set_cmd(1, 5, 5, 2, 1, 16'h000B);
    req = 2'b11;
    wait_done(4, 200, 1'b0, ok);
    req = 2'b00;
    chk("rr_four_done", ok, 1'b1);
    if (ok) begin
      chk("rr_grant0", done_log[0], 2'b01);
      chk("rr_grant1", done_log[1], 2'b10);
      chk("rr_grant2", done_log[2], 2'b01);
      chk("rr_grant3", done_log[3], 2'b10);
    end
    chk("rr_px_total", px_log.size(), 6);
    tick();
    tick();

    // Reset at the third pixel, then both request: requester 0 wins
    px_log.delete();
    done_log.delete();
    set_cmd(0, 10, 20, 3, 2, 16'hF00D);
    req = 2'b01;
    for (int c = 0; c < 50; c++) begin
      tick();
      if (pixelWrite && xAddr == 8'd12) break;
    end
    chk("mid_reached_third", {pixelWrite, xAddr}, {1'b1, 8'd12});
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_grant", grant, 2'b00);
    chk("mid_rst_done", done, 2'b00);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_write", pixelWrite, 1'b0);
    chk("mid_rst_addr_data", {xAddr, yAddr, pixelData}, 33'd0);
    tick();
    tick();
    chk("mid_no_done", done_log.size(), 0);
    reset_n = 1'b1;
    px_log.delete();
    set_cmd(1, 50, 50, 1, 1, 16'h0BAD);
    req = 2'b11;
    tick();
    chk("mid_regrant", grant, 2'b01);
    req = 2'b00;
    wait_done(1, 100, 1'b0, ok);
    chk("mid_done_seen", ok, 1'b1);
    if (ok) chk("mid_done_owner", done_log[0], 2'b01);
    check_rect("mid", 6, 10, 12, 20, 21, 16'hF00D);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
